// File: rtl/div_unit_if.sv
// Request/response bundle between the control path and the iterative divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             u;
  logic             rem_sel;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] div_result;

  modport master (
    output start, u, rem_sel, src1, src2,
    input  busy, done, div_result
  );

  modport slave (
    input  start, u, rem_sel, src1, src2,
    output busy, done, div_result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with divide-by-zero and signed overflow resolved at the start edge.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
  logic             rem_sel_q, neg_quo_q, neg_rem_q;

  logic             sgn1, sgn2, div_zero, ovf, special;
  logic [WIDTH-1:0] mag1, mag2, special_res;
  logic [WIDTH:0]   rem_shift, diff;
  logic [WIDTH-1:0] quo_nxt, rem_nxt, quo_fix, rem_fix;

  // Operand decode at the start edge
  always_comb begin
    sgn1        = ~bus.u & bus.src1[WIDTH-1];
    sgn2        = ~bus.u & bus.src2[WIDTH-1];
    mag1        = sgn1 ? -bus.src1 : bus.src1;
    mag2        = sgn2 ? -bus.src2 : bus.src2;
    div_zero    = (bus.src2 == '0);
    ovf         = ~bus.u && (bus.src1 == MinVal) && (bus.src2 == '1);
    special     = div_zero | ovf;
    special_res = div_zero ? (bus.rem_sel ? bus.src1 : '1)
                           : (bus.rem_sel ? '0 : MinVal);
  end

  // One restoring step; the MSB of the (WIDTH+1)-bit difference is its sign
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    quo_nxt   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_nxt   = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_fix   = neg_quo_q ? -quo_nxt : quo_nxt;
    rem_fix   = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = special ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q == StCalc);
    bus.done       = (state_q == StDone);
    bus.div_result = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            rem_sel_q <= bus.rem_sel;
            neg_quo_q <= sgn1 ^ sgn2;
            neg_rem_q <= sgn1;
            dvs_q     <= mag2;
            quo_q     <= mag1;
            rem_q     <= '0;
            cnt_q     <= CntW'(WIDTH - 1);
            if (special) begin
              result_q <= special_res;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            result_q <= rem_sel_q ? rem_fix : quo_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results and
// latencies, popped and compared when done pulses.
module tb_div_unit;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [W-1:0] res;
    int         lat;
  } exp_t;

  typedef struct {
    logic       u;
    logic       rs;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [W-1:0] model(input logic u, input logic rs,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!u && a == MinVal && b == '1) begin
      q = MinVal;
      r = '0;
    end else if (u) begin
      q = a / b;
      r = a % b;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return rs ? r : q;
  endfunction

  // Drives one start edge and records what the DUT owes us.
  task automatic issue(input string name, input logic u, input logic rs,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.lat  = (b == '0 || (!u && a == MinVal && b == '1)) ? 1 : W + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.u       = u;
    bus.rem_sel = rs;
    bus.src1    = a;
    bus.src2    = b;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.u       = ~u;
    bus.rem_sel = ~rs;
    bus.src1    = $urandom;
    bus.src2    = $urandom;
  endtask

  // Called at start edge + 1; returns cycle of done and whether busy tracked CALC.
  task automatic wait_done(output int cyc, output bit busy_ok, output logic [W-1:0] res,
                           output bit timeout);
    cyc     = 1;
    busy_ok = 1'b1;
    timeout = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc >= 100) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (bus.busy !== 1'b0) busy_ok = 1'b0;
    res = bus.div_result;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.u = 1'b0; bus.rem_sel = 1'b0; bus.src1 = '0; bus.src2 = '0;
    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_result !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h expected 0/0/0",
               bus.busy, bus.done, bus.div_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    vec_t tbl[5];
    int cyc; bit bok, tmo; logic [W-1:0] res; exp_t e;
    tbl = '{'{1'b1, 1'b0, 32'd100, 32'd7, 32'd14},
            '{1'b1, 1'b1, 32'd100, 32'd7, 32'd2},
            '{1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
            '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
            '{1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1}};
    foreach (tbl[i]) begin
      issue($sformatf("basic%0d", i), tbl[i].u, tbl[i].rs, tbl[i].a, tbl[i].b, tbl[i].res);
      wait_done(cyc, bok, res, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || res !== e.res) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", e.name, res, e.res);
      end
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
      end
      checks++;
      if (!bok || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/done: busy_ok=%b done_after=%b expected 1/0", e.name, bok,
                 bus.done);
      end
    end
  endtask

  task automatic test_special();
    vec_t tbl[4];
    int cyc; bit bok, tmo; logic [W-1:0] res; exp_t e;
    tbl = '{'{1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF},
            '{1'b1, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678},
            '{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0}};
    foreach (tbl[i]) begin
      issue($sformatf("special%0d", i), tbl[i].u, tbl[i].rs, tbl[i].a, tbl[i].b, tbl[i].res);
      wait_done(cyc, bok, res, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || res !== e.res) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", e.name, res, e.res);
      end
      checks++;
      if (cyc !== e.lat || !bok) begin
        errors++;
        $display("FAIL %s latency: got %0d busy_ok=%b expected %0d/1", e.name, cyc, bok, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok, tmo; logic [W-1:0] res, a, b; logic u, rs; exp_t e;
    for (int i = 0; i < 12; i++) begin
      u  = i[0];
      rs = i[1];
      a  = $urandom;
      b  = (i == 5) ? '0 : ((i % 3 == 0) ? W'($urandom_range(1, 300)) : W'($urandom));
      if (i == 7) b = '1;
      issue($sformatf("b2b%0d", i), u, rs, a, b, model(u, rs, a, b));
      wait_done(cyc, bok, res, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || res !== e.res || cyc !== e.lat) begin
        errors++;
        $display("FAIL %s: got %h lat %0d expected %h lat %0d", e.name, res, cyc, e.res, e.lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, dones, busys; logic [W-1:0] res; exp_t e;
    issue("ignore", 1'b1, 1'b0, 32'd100, 32'd7, 32'd14);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        bus.start = 1'b1; bus.u = 1'b0; bus.rem_sel = 1'b1;
        bus.src1 = 32'd1000; bus.src2 = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    res = bus.div_result;
    e = sb.pop_front();
    checks++;
    if (res !== e.res || cyc !== e.lat) begin
      errors++;
      $display("FAIL ignore_calc: got %h lat %0d expected %h lat %0d", res, cyc, e.res, e.lat);
    end
    bus.start = 1'b1; bus.src1 = 32'd9; bus.src2 = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0; busys = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busys++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones != 0 || busys != 0 || bus.div_result !== 32'd14) begin
      errors++;
      $display("FAIL ignore_done: got dones=%0d busy=%0d res=%h expected 0/0/%h", dones, busys,
               bus.div_result, 32'd14);
    end
  endtask

  task automatic test_async_reset();
    int cyc; bit bok, tmo; logic [W-1:0] res; exp_t e;
    issue("rst_abort", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_result !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b res=%h expected 0/0/0",
               bus.busy, bus.done, bus.div_result);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    issue("after_rst", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    wait_done(cyc, bok, res, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || res !== e.res || cyc !== e.lat || !bok) begin
      errors++;
      $display("FAIL %s: got %h lat %0d busy_ok=%b expected %h lat %0d", e.name, res, cyc, bok,
               e.res, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
